conv_result_buffer: RTL
=======================

// Module: conv_result_buffer
// PURPOSE
//   Downstream stage of the pe / sa2x2 / sa3x3 compute arrays.
//   Captures the 8-bit array output on the controller's one-hot capture strobes (c00..c11) into a 2x2 result matrix.
//   On done, drains the four results to the lcd stage in row-major order over a valid/ready handshake.
//   One instance per array; each sits between the array's out port and the lcd.
// PARAMETERS
//   DATA_W  8  width of array output and stored results
// PORTS
//   clk        in   1       system clock; all logic on rising edge
//   rst        in   1       synchronous, active-high reset
//   clear      in   1       synchronous restart: empties buffer, clears err
//   din        in   DATA_W  array output (out of pe/sa2x2/sa3x3)
//   c00        in   1       capture din into slot 0 (row 0, col 0)
//   c01        in   1       capture din into slot 1
//   c10        in   1       capture din into slot 2
//   c11        in   1       capture din into slot 3
//   done       in   1       controller: computation finished, start drain
//   res_valid  out  1       res_data/res_idx valid this cycle
//   res_ready  in   1       lcd accepts current element
//   res_data   out  DATA_W  result element
//   res_idx    out  2       slot index of res_data (0..3)
//   res_last   out  1       high with res_valid when res_idx==3
//   busy       out  1       state != IDLE
//   err        out  1       sticky protocol-error flag
// BEHAVIOUR
//   Reset (rst=1): state=IDLE, slots=0, filled=4'b0, idx=0, err=0.
//     All outputs 0 at the first edge after rst asserts.
//   rst has priority over clear; clear has priority over every other input.
//   clear: same effect as rst; legal in any state and aborts a drain in progress.
//   FSM
//     IDLE    : any strobe -> store it, go CAPTURE. done with no strobe -> err=1, stay IDLE.
//     CAPTURE : store strobes.
//               done -> DRAIN, idx=0.
//               If filled!=4'hF when done is sampled (including a strobe in the same cycle), set err=1; unfilled slots drain as 0.
//     DRAIN   : res_valid=1, res_data=slot[idx], res_idx=idx, res_last=(idx==3).
//               On res_valid&&res_ready: idx+1.
//               On the transfer with idx==3: go IDLE, clear slots and filled.
//   Capture rules
//     Strobe sampled at edge N: slot and filled bit updated at N, visible from N+1.
//     More than one strobe in one cycle: capture the lowest-index one only, err=1.
//     Strobe to an already-filled slot: overwrite, err=1.
//     Strobe during DRAIN: ignored (slots unchanged), err=1.
//     Strobe and done in the same cycle (CAPTURE): strobe is stored first, then the filled check runs, then the FSM goes DRAIN.
//   Handshake
//     res_data, res_idx and res_last are held stable while res_valid && !res_ready.
//     res_valid never drops before the transfer completes, except on rst/clear.
//     Max throughput: 1 element per cycle. done asserted at edge N -> res_valid=1 from N+1.
//   done during DRAIN: ignored, no error.
//   Data is stored raw; no arithmetic, no saturation.
//   busy=1 in CAPTURE and DRAIN.
//   err: sticky until rst/clear; does not alter the FSM.
// TESTING
//   1. Strobes c00,c01,c10,c11 with din=5,9,12,20 on 4 cycles, done, res_ready=1
//      -> 4 transfers 5,9,12,20; idx 0..3; res_last on 20; err=0; busy=0 after.
//   2. Same as 1 but res_ready toggles 1,0,0,1...
//      -> data/idx held during stalls; exactly 4 transfers, in order.
//   3. c01 and c10 together, din=7
//      -> slot1=7, slot2 untouched, err=1. done -> drains 0,7,0,0; err stays 1.
//   4. Only c00=3, c11=4, then done
//      -> err=1; drain 3,0,0,4.
//   5. clear asserted after 2 of 4 transfers
//      -> next cycle res_valid=0, busy=0, err=0, slots 0. A fresh capture of 1,2,3,4 works.
//   6. rst mid-CAPTURE; then c11 with done in the same cycle after a full fill (c00..c10 prior)
//      -> after rst all outputs 0; second case drains all 4 with err=0.

Source files
------------

// File: rtl/conv_result_buffer_if.sv
// Result handshake between conv_result_buffer and the lcd stage.
//   res_valid : element on res_data/res_idx is valid this cycle
//   res_ready : lcd accepts the current element
//   res_data  : result element
//   res_idx   : slot index of res_data (0..3, row-major)
//   res_last  : final element of the 2x2 drain
// master = buffer side (drives data), slave = lcd side (drives ready).
interface conv_result_buffer_if #(
  parameter int DATA_W = 8
);
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [1:0]        res_idx;
  logic              res_last;

  modport master (
    output res_valid,
    output res_data,
    output res_idx,
    output res_last,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_data,
    input  res_idx,
    input  res_last,
    output res_ready
  );
endinterface

// File: rtl/conv_result_buffer.sv
// Captures an array's 8-bit output into a 2x2 result matrix on one-hot
// capture strobes, then drains the four results in row-major order to the
// lcd stage over a valid/ready handshake.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset (priority over clear_i)
//   clear_i    : synchronous restart, same effect as rst
//   din_i      : array output
//   c00_i..c11_i : capture strobes for slots 0..3
//   done_i     : computation finished, start drain
//   res        : result handshake (master side)
//   busy_o     : FSM not idle
//   err_o      : sticky protocol-error flag
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | empty, waiting for the first capture strobe
// CAPTURE | collecting results into the slots
// DRAIN   | presenting slot[idx] to the lcd, idx 0..3
module conv_result_buffer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              c00_i,
  input  logic              c01_i,
  input  logic              c10_i,
  input  logic              c11_i,
  input  logic              done_i,
  conv_result_buffer_if.master res,
  output logic              busy_o,
  output logic              err_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] DRAIN   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] slots_q [4];
  logic [DATA_W-1:0] slots_d [4];
  logic [3:0]        filled_q, filled_d;
  logic [1:0]        idx_q, idx_d;
  logic              err_q, err_d;

  logic [3:0] strobe;
  logic       any_strobe;
  logic       multi_strobe;
  logic [1:0] sel;
  logic [3:0] sel_mask;
  logic       draining;
  logic       xfer;

  assign strobe       = {c11_i, c10_i, c01_i, c00_i};
  assign any_strobe   = |strobe;
  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi_strobe = (strobe & (strobe - 4'd1)) != 4'd0;
  assign draining     = (state_q == DRAIN);
  assign xfer         = draining && res.res_ready;

  // Lowest-index strobe wins when several fire together.
  always_comb begin
    sel = 2'd0;
    if (c00_i)      sel = 2'd0;
    else if (c01_i) sel = 2'd1;
    else if (c10_i) sel = 2'd2;
    else if (c11_i) sel = 2'd3;
  end

  assign sel_mask = 4'b0001 << sel;

  always_comb begin
    state_d  = state_q;
    slots_d  = slots_q;
    filled_d = filled_q;
    idx_d    = idx_q;
    err_d    = err_q;

    if (state_q != DRAIN) begin
      if (any_strobe) begin
        slots_d[sel] = din_i;
        filled_d     = filled_q | sel_mask;
        if (multi_strobe || ((filled_q & sel_mask) != 4'd0)) err_d = 1'b1;
        state_d = CAPTURE;
      end
      if (done_i) begin
        if (state_q == IDLE && !any_strobe) begin
          err_d = 1'b1;
        end else begin
          // filled_d already includes a same-cycle strobe.
          if (filled_d != 4'hF) err_d = 1'b1;
          state_d = DRAIN;
          idx_d   = 2'd0;
        end
      end
    end else begin
      if (any_strobe) err_d = 1'b1;
      if (xfer) begin
        if (idx_q == 2'd3) begin
          state_d  = IDLE;
          filled_d = 4'd0;
          idx_d    = 2'd0;
          for (int i = 0; i < 4; i++) slots_d[i] = '0;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      state_q  <= IDLE;
      filled_q <= 4'd0;
      idx_q    <= 2'd0;
      err_q    <= 1'b0;
      for (int i = 0; i < 4; i++) slots_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      filled_q <= filled_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      for (int i = 0; i < 4; i++) slots_q[i] <= slots_d[i];
    end
  end

  // Outputs are forced to zero outside DRAIN so nothing stale leaks out.
  assign res.res_valid = draining;
  assign res.res_data  = draining ? slots_q[idx_q] : '0;
  assign res.res_idx   = draining ? idx_q : 2'd0;
  assign res.res_last  = draining && (idx_q == 2'd3);
  assign busy_o        = (state_q != IDLE);
  assign err_o         = err_q;

endmodule
